// File: rtl/cache_way_select.sv
// ---------------------------------------------------------------------------
// cache_way_select
//   Registered N-way read-data selector for the set-associative cache read
//   path. Picks the hit way's word from the per-way data using the tag-hit
//   vector and presents it through one valid/ready pipeline stage. On a miss
//   it reports a round-robin victim way for refill. It also flags multi-hit
//   tag corruption.
//
// Parameters
//   WAYS   number of cache ways (>= 2, any value)
//   WIDTH  data word width in bits
//
// Ports
//   clk           rising-edge clock
//   rst_n         asynchronous active-low reset
//   in_valid      hit_vec / way_data valid this cycle
//   in_ready      stage can accept an input this cycle
//   hit_vec       tag hit per way (bit i = way i)
//   way_data      way i word at [i*WIDTH +: WIDTH]
//   out_valid     output fields hold a result
//   out_ready     consumer accepts the result
//   out_data      selected word (0 on miss)
//   out_hit       at least one way hit
//   out_way       hit way index, or the victim way index on a miss
//   out_multihit  more than one hit bit was set
// ---------------------------------------------------------------------------
module cache_way_select #(
  parameter int WAYS  = 4,
  parameter int WIDTH = 8,
  localparam int WAY_BITS = $clog2(WAYS)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [WAYS-1:0]       hit_vec,
  input  logic [WAYS*WIDTH-1:0] way_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WIDTH-1:0]      out_data,
  output logic                  out_hit,
  output logic [WAY_BITS-1:0]   out_way,
  output logic                  out_multihit
);

  // Registered state
  logic                out_valid_q, out_valid_d;
  logic [WIDTH-1:0]    out_data_q, out_data_d;
  logic                out_hit_q, out_hit_d;
  logic [WAY_BITS-1:0] out_way_q, out_way_d;
  logic                out_multihit_q, out_multihit_d;
  logic [WAY_BITS-1:0] vptr_q, vptr_d;

  // Combinational selection results
  logic [WIDTH-1:0]    sel_data;
  logic                sel_hit;
  logic [WAY_BITS-1:0] sel_way;
  logic                sel_multi;
  logic                accept;

  // A full stage frees up in the same cycle the consumer takes its result.
  assign in_ready = !out_valid_q || out_ready;
  assign accept   = in_valid && in_ready;

  always_comb begin
    // NOTE: every variable gets a default before any conditional assignment so
    // no path leaves it unassigned, which would infer a latch.
    sel_data = '0;
    sel_hit  = 1'b0;
    sel_way  = vptr_q;
    // Scan from the top down so the lowest set index is the one left standing.
    for (int i = WAYS - 1; i >= 0; i--) begin
      if (hit_vec[i]) begin
        sel_hit  = 1'b1;
        sel_way  = WAY_BITS'(i);
        sel_data = way_data[i*WIDTH +: WIDTH];
      end
    end
    // Clearing the lowest set bit leaves something only if two or more were set.
    sel_multi = |(hit_vec & (hit_vec - WAYS'(1)));
  end

  always_comb begin
    out_valid_d    = out_valid_q;
    out_data_d     = out_data_q;
    out_hit_d      = out_hit_q;
    out_way_d      = out_way_q;
    out_multihit_d = out_multihit_q;
    vptr_d         = vptr_q;

    if (accept) begin
      out_valid_d    = 1'b1;
      out_data_d     = sel_data;
      out_hit_d      = sel_hit;
      out_way_d      = sel_way;
      out_multihit_d = sel_multi;
      // Only a miss consumes a victim slot.
      if (!sel_hit) begin
        vptr_d = (vptr_q == WAY_BITS'(WAYS - 1)) ? '0 : vptr_q + 1'b1;
      end
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // NOTE: sequential state is written with non-blocking assignments so every
  // flop samples its pre-edge inputs regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q    <= 1'b0;
      out_data_q     <= '0;
      out_hit_q      <= 1'b0;
      out_way_q      <= '0;
      out_multihit_q <= 1'b0;
      vptr_q         <= '0;
    end else begin
      out_valid_q    <= out_valid_d;
      out_data_q     <= out_data_d;
      out_hit_q      <= out_hit_d;
      out_way_q      <= out_way_d;
      out_multihit_q <= out_multihit_d;
      vptr_q         <= vptr_d;
    end
  end

  assign out_valid    = out_valid_q;
  assign out_data     = out_data_q;
  assign out_hit      = out_hit_q;
  assign out_way      = out_way_q;
  assign out_multihit = out_multihit_q;

endmodule

// File: tb/tb_cache_way_select.sv
// ---------------------------------------------------------------------------
// tb_cache_way_select
//   Directed bench for cache_way_select (WAYS=4, WIDTH=8). Inputs are driven
//   1 time unit after each rising edge; outputs are sampled at the same point,
//   i.e. they reflect the inputs presented before that edge.
// ---------------------------------------------------------------------------
module tb_cache_way_select;

  localparam int WAYS  = 4;
  localparam int WIDTH = 8;

  logic                  clk;
  logic                  rst_n;
  logic                  in_valid;
  logic                  in_ready;
  logic [WAYS-1:0]       hit_vec;
  logic [WAYS*WIDTH-1:0] way_data;
  logic                  out_valid;
  logic                  out_ready;
  logic [WIDTH-1:0]      out_data;
  logic                  out_hit;
  logic [1:0]            out_way;
  logic                  out_multihit;

  int n_checks = 0;
  int n_errors = 0;

  cache_way_select #(.WAYS(WAYS), .WIDTH(WIDTH)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .hit_vec      (hit_vec),
    .way_data     (way_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .out_hit      (out_hit),
    .out_way      (out_way),
    .out_multihit (out_multihit)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Check every output field at once.
  task automatic check_out(input string tag, input logic v, input logic [7:0] d,
                           input logic h, input logic [1:0] w, input logic m);
    check({tag, ".valid"}, 32'(out_valid), 32'(v));
    check({tag, ".data"}, 32'(out_data), 32'(d));
    check({tag, ".hit"}, 32'(out_hit), 32'(h));
    check({tag, ".way"}, 32'(out_way), 32'(w));
    check({tag, ".multihit"}, 32'(out_multihit), 32'(m));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [1:0]  exp_vptr;
    logic [7:0]  e_data;
    logic        e_hit;
    logic [1:0]  e_way;
    logic        e_mh;
    logic [7:0]  w_arr [WAYS];
    logic [1:0]  miss_way [5];

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    hit_vec   = '0;
    way_data  = '0;

    // Power-on reset state
    step();
    check_out("por", 1'b0, 8'h00, 1'b0, 2'd0, 1'b0);
    check("por.in_ready", 32'(in_ready), 32'd1);
    rst_n = 1'b1;
    step();

    // Single hit on way 2
    in_valid  = 1'b1;
    out_ready = 1'b1;
    hit_vec   = 4'b0100;
    way_data  = {8'hDD, 8'hCC, 8'hBB, 8'hAA};
    #1;
    check("single.in_ready", 32'(in_ready), 32'd1);
    step();
    check_out("single", 1'b1, 8'hCC, 1'b1, 2'd2, 1'b0);

    // Multi-hit: ways 1 and 3, lowest wins (back-to-back)
    hit_vec = 4'b1010;
    step();
    check_out("multi", 1'b1, 8'hBB, 1'b1, 2'd1, 1'b1);

    // Victim wrap with a hit inserted: ways 0,1,(hit 3),2,3,0.
    // Way data is all ones so a leaking miss word would show.
    miss_way[0] = 2'd0; miss_way[1] = 2'd1; miss_way[2] = 2'd2;
    miss_way[3] = 2'd3; miss_way[4] = 2'd0;
    way_data = {4{8'hFF}};
    for (int i = 0; i < 5; i++) begin
      if (i == 2) begin
        hit_vec  = 4'b1000;
        way_data = {8'h5A, 8'hFF, 8'hFF, 8'hFF};
        step();
        check_out("wrap.hit", 1'b1, 8'h5A, 1'b1, 2'd3, 1'b0);
        way_data = {4{8'hFF}};
      end
      hit_vec = 4'b0000;
      step();
      check_out($sformatf("wrap.miss%0d", i), 1'b1, 8'h00, 1'b0, miss_way[i], 1'b0);
    end

    // Back-pressure: hold a miss result (way 0) while a hit is pending.
    out_ready = 1'b0;
    hit_vec   = 4'b0001;
    way_data  = {8'h44, 8'h33, 8'h22, 8'h11};
    #1;
    check("bp.in_ready0", 32'(in_ready), 32'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      check_out($sformatf("bp.hold%0d", i), 1'b1, 8'h00, 1'b0, 2'd0, 1'b0);
      check($sformatf("bp.in_ready%0d", i), 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    #1;
    check("bp.release_ready", 32'(in_ready), 32'd1);
    step();
    check_out("bp.taken", 1'b1, 8'h11, 1'b1, 2'd0, 1'b0);

    // Victim pointer did not move during the stall or the hit: next miss is way 1.
    hit_vec = 4'b0000;
    step();
    check_out("bp.miss", 1'b1, 8'h00, 1'b0, 2'd1, 1'b0);

    // Drain: no input, consumer ready -> out_valid falls.
    in_valid = 1'b0;
    step();
    check("drain.valid", 32'(out_valid), 32'd0);
    check("drain.in_ready", 32'(in_ready), 32'd1);

    // Streaming: 16 back-to-back random transfers against a reference model.
    exp_vptr  = 2'd2;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    for (int n = 0; n < 16; n++) begin
      hit_vec = 4'($urandom_range(0, 15));
      if (n % 4 == 0) hit_vec = 4'b0000;
      for (int w = 0; w < WAYS; w++) w_arr[w] = 8'($urandom);
      way_data = {w_arr[3], w_arr[2], w_arr[1], w_arr[0]};
      e_hit  = 1'b0;
      e_data = 8'h00;
      e_way  = exp_vptr;
      e_mh   = 1'b0;
      for (int w = 0; w < WAYS; w++) begin
        if (hit_vec[w]) begin
          if (e_hit) e_mh = 1'b1;
          else begin
            e_hit  = 1'b1;
            e_data = w_arr[w];
            e_way  = 2'(w);
          end
        end
      end
      if (!e_hit) exp_vptr = (exp_vptr == 2'd3) ? 2'd0 : exp_vptr + 2'd1;
      step();
      check_out($sformatf("stream%0d", n), 1'b1, e_data, e_hit, e_way, e_mh);
    end

    // Asynchronous reset mid-cycle while a result is held.
    out_ready = 1'b0;
    hit_vec   = 4'b0010;
    way_data  = {8'h04, 8'h03, 8'h02, 8'h01};
    step();
    check("rst.pre_valid", 32'(out_valid), 32'd1);
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check_out("rst.async", 1'b0, 8'h00, 1'b0, 2'd0, 1'b0);
    check("rst.in_ready", 32'(in_ready), 32'd1);
    step();
    rst_n = 1'b1;
    #1;
    check("rst.release_ready", 32'(in_ready), 32'd1);

    // Victim pointer was cleared by reset: first miss is way 0.
    in_valid = 1'b1;
    out_ready = 1'b1;
    hit_vec  = 4'b0000;
    step();
    check_out("rst.miss", 1'b1, 8'h00, 1'b0, 2'd0, 1'b0);
    in_valid = 1'b0;
    step();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
